// File: rtl/irrigation_scheduler_pkg.sv
// Shared types for the irrigation scheduler slice:
// rain levels and the burst FSM state encoding.
package irrigacao_pkg;

  typedef enum logic [1:0] {
    NENHUMA,
    POUCA,
    MUITA,
    DILUVIO
  } rain_t;

  typedef enum logic [1:0] {
    IDLE,
    WATER_LOW,
    WATER_DRY
  } irr_state_t;

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Board-side bundle of the scheduler: rain sensor, enable and
// alarm ack in; per-plant valves, alarm and busy out.
interface irrigation_scheduler_if #(
  parameter int NPLANTS = 2
);
  logic [1:0]         chuva;
  logic               enable;
  logic               alarm_ack;
  logic [NPLANTS-1:0] water;
  logic               alarm;
  logic               busy;

  modport master (
    output chuva, enable, alarm_ack,
    input  water, alarm, busy
  );

  modport slave (
    input  chuva, enable, alarm_ack,
    output water, alarm, busy
  );
endinterface

// File: rtl/irrigation_scheduler_rain_run_counter.sv
// Tracks the last rain level and a saturating run length.
// Ports: clk_2, reset, chuva_i, clr_i in; run_cnt_o (post-update) out.
module rain_run_counter
  import irrigacao_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  rain_t            chuva_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] run_cnt_o
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] run_q, run_d;
  rain_t            lvl_q;

  // run_cnt_o is the count including this sample, so the
  // trigger decode sees the run before it gets cleared.
  always_comb begin
    run_cnt_o = ONE;
    if (chuva_i == lvl_q)
      run_cnt_o = (run_q == MAX) ? MAX : run_q + ONE;
    run_d = clr_i ? '0 : run_cnt_o;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      run_q <= '0;
      lvl_q <= NENHUMA;
    end else begin
      run_q <= run_d;
      lvl_q <= chuva_i;
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Multi-plant irrigation controller: rain runs trigger schedules.
// Ports: clk_2, reset, bus (chuva/enable/alarm_ack in; water/alarm/busy out).
module irrigation_scheduler
  import irrigacao_pkg::*;
#(
  parameter int NPLANTS   = 2,
  parameter int CNT_W     = 4,
  parameter int LOW_RUN   = 2,
  parameter int DRY_RUN   = 3,
  parameter int FLOOD_RUN = 3,
  parameter int LOW_BURST = 2,
  parameter int DRY_BURST = 3,
  parameter logic [NPLANTS*CNT_W-1:0] LOW_START = 8'h00,
  parameter logic [NPLANTS*CNT_W-1:0] LOW_LEN   = 8'h10,
  parameter logic [NPLANTS*CNT_W-1:0] DRY_START = 8'h02,
  parameter logic [NPLANTS*CNT_W-1:0] DRY_LEN   = 8'h21
) (
  input  logic clk_2,
  input  logic reset,
  irrigation_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(LOW_BURST - 1);
  localparam logic [CNT_W-1:0] DRY_LAST = CNT_W'(DRY_BURST - 1);

  rain_t            lvl;
  logic [CNT_W-1:0] run_cnt;
  logic             low_trig, dry_trig, flood_trig;
  logic             idle, abort, done;
  logic [CNT_W-1:0] last;
  irr_state_t       state_q, start_st;
  logic [CNT_W-1:0] burst_q;
  logic             alarm_q;
  logic [NPLANTS-1:0] water_w;

  assign lvl = rain_t'(bus.chuva);

  rain_run_counter #(.CNT_W(CNT_W)) u_run (
    .clk_2     (clk_2),
    .reset     (reset),
    .chuva_i   (lvl),
    .clr_i     (low_trig | dry_trig | flood_trig),
    .run_cnt_o (run_cnt)
  );

  assign low_trig   = (lvl == POUCA)   && (run_cnt == CNT_W'(LOW_RUN));
  assign dry_trig   = (lvl == NENHUMA) && (run_cnt == CNT_W'(DRY_RUN));
  assign flood_trig = (lvl == DILUVIO) && (run_cnt == CNT_W'(FLOOD_RUN));

  always_comb begin
    start_st = IDLE;
    if (bus.enable && low_trig)      start_st = WATER_LOW;
    else if (bus.enable && dry_trig) start_st = WATER_DRY;
  end

  assign idle  = (state_q == IDLE);
  assign last  = (state_q == WATER_LOW) ? LOW_LAST : DRY_LAST;
  assign abort = !idle && (bus.chuva[1] || !bus.enable);
  assign done  = !idle && !abort && (burst_q == last);

  // The completion edge is no longer busy, so a trigger landing
  // on it chains straight into the next burst.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      if (flood_trig)         alarm_q <= 1'b1;
      else if (bus.alarm_ack) alarm_q <= 1'b0;
      unique case (1'b1)
        idle, done: begin
          state_q <= start_st;
          burst_q <= '0;
        end
        abort: state_q <= IDLE;
        default: burst_q <= burst_q + CNT_W'(1);
      endcase
    end
  end

  // Extra bit keeps start+len from wrapping.
  function automatic logic in_win(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] st,
    input logic [CNT_W-1:0] ln
  );
    logic [CNT_W:0] c, s, e;
    c = {1'b0, cnt};
    s = {1'b0, st};
    e = s + {1'b0, ln};
    return (c >= s) && (c < e);
  endfunction

  always_comb begin
    water_w = '0;
    for (int i = 0; i < NPLANTS; i++) begin
      if (state_q == WATER_LOW)
        water_w[i] = in_win(burst_q,
          LOW_START[i*CNT_W +: CNT_W],
          LOW_LEN[i*CNT_W +: CNT_W]);
      else if (state_q == WATER_DRY)
        water_w[i] = in_win(burst_q,
          DRY_START[i*CNT_W +: CNT_W],
          DRY_LEN[i*CNT_W +: CNT_W]);
    end
  end

  assign bus.water = water_w;
  assign bus.alarm = alarm_q;
  assign bus.busy  = !idle;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: directed rain
// sequences push expected water/busy/alarm, a monitor compares.
module tb_irrigation_scheduler;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;

  irrigation_scheduler_if #(.NPLANTS(2)) bus ();

  irrigation_scheduler dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [1:0] w;
    logic       b;
    logic       a;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    bus.chuva     = 2'd0;
    bus.enable    = 1'b1;
    bus.alarm_ack = 1'b0;
  end

  // Monitor: one expectation per clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2 or posedge reset);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.water !== e.w) begin
          errors++;
          $display("FAIL %s water got %b want %b", e.nm, bus.water, e.w);
        end
        checks++;
        if (bus.busy !== e.b) begin
          errors++;
          $display("FAIL %s busy got %b want %b", e.nm, bus.busy, e.b);
        end
        checks++;
        if (bus.alarm !== e.a) begin
          errors++;
          $display("FAIL %s alarm got %b want %b", e.nm, bus.alarm, e.a);
        end
      end
    end
  end

  // Called at a negedge; drives, queues the post-edge expectation.
  task automatic step(
    input logic [1:0] c, input logic en, input logic ack,
    input logic [1:0] w, input logic b, input logic a,
    input string nm
  );
    exp_t e;
    bus.chuva     = c;
    bus.enable    = en;
    bus.alarm_ack = ack;
    e.w = w; e.b = b; e.a = a; e.nm = nm;
    q.push_back(e);
    @(negedge clk_2);
  endtask

  task automatic expect_now(input string nm);
    exp_t e;
    e.w = 2'b00; e.b = 1'b0; e.a = 1'b0; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    expect_now("reset");
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;

    // 1: DRY burst from three nenhuma samples
    step(0, 1, 0, 2'b00, 0, 0, "t1_s1");
    step(0, 1, 0, 2'b00, 0, 0, "t1_s2");
    step(0, 1, 0, 2'b10, 1, 0, "t1_trig");
    step(0, 1, 0, 2'b10, 1, 0, "t1_c2");
    step(0, 1, 0, 2'b01, 1, 0, "t1_c3");
    step(1, 1, 0, 2'b00, 0, 0, "t1_end");
    // 2: LOW burst, then broken pouca run
    step(1, 1, 0, 2'b10, 1, 0, "t2_trig");
    step(1, 1, 0, 2'b00, 1, 0, "t2_c2");
    step(0, 1, 0, 2'b00, 0, 0, "t2_end");
    step(1, 1, 0, 2'b00, 0, 0, "t2_b1");
    step(0, 1, 0, 2'b00, 0, 0, "t2_b0");
    step(1, 1, 0, 2'b00, 0, 0, "t2_b1b");
    // 3: heavy rain aborts DRY burst at burst_cnt 1
    step(0, 1, 0, 2'b00, 0, 0, "t3_s1");
    step(0, 1, 0, 2'b00, 0, 0, "t3_s2");
    step(0, 1, 0, 2'b10, 1, 0, "t3_trig");
    step(0, 1, 0, 2'b10, 1, 0, "t3_c2");
    step(2, 1, 0, 2'b00, 0, 0, "t3_abort");
    step(2, 1, 0, 2'b00, 0, 0, "t3_muita");
    // 4: flood alarm, ack vs retrigger, final clear
    step(3, 1, 0, 2'b00, 0, 0, "t4_f1");
    step(3, 1, 0, 2'b00, 0, 0, "t4_f2");
    step(3, 1, 0, 2'b00, 0, 1, "t4_set");
    step(3, 1, 1, 2'b00, 0, 0, "t4_ack1");
    step(3, 1, 1, 2'b00, 0, 0, "t4_ack2");
    step(3, 1, 1, 2'b00, 0, 1, "t4_setwins");
    step(0, 1, 1, 2'b00, 0, 0, "t4_clear");
    step(2, 1, 0, 2'b00, 0, 0, "t4_break");
    // 5: sustained nenhuma retriggers every 3 samples
    step(0, 1, 0, 2'b00, 0, 0, "t5_s1");
    step(0, 1, 0, 2'b00, 0, 0, "t5_s2");
    step(0, 1, 0, 2'b10, 1, 0, "t5_s3");
    step(0, 1, 0, 2'b10, 1, 0, "t5_s4");
    step(0, 1, 0, 2'b01, 1, 0, "t5_s5");
    step(0, 1, 0, 2'b10, 1, 0, "t5_s6");
    step(0, 1, 0, 2'b10, 1, 0, "t5_s7");
    step(0, 1, 0, 2'b01, 1, 0, "t5_s8");
    step(2, 1, 0, 2'b00, 0, 0, "t5_stop");
    step(0, 0, 0, 2'b00, 0, 0, "t5_dis1");
    step(0, 0, 0, 2'b00, 0, 0, "t5_dis2");
    step(0, 0, 0, 2'b00, 0, 0, "t5_dis3");
    step(0, 0, 0, 2'b00, 0, 0, "t5_dis4");
    // 6: alarm up, burst, async reset mid-burst
    step(3, 1, 0, 2'b00, 0, 0, "t6_f1");
    step(3, 1, 0, 2'b00, 0, 0, "t6_f2");
    step(3, 1, 0, 2'b00, 0, 1, "t6_alarm");
    step(0, 1, 0, 2'b00, 0, 1, "t6_s1");
    step(0, 1, 0, 2'b00, 0, 1, "t6_s2");
    step(0, 1, 0, 2'b10, 1, 1, "t6_trig");
    step(0, 1, 0, 2'b10, 1, 1, "t6_c2");
    #2;
    expect_now("t6_reset");
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    step(0, 1, 0, 2'b00, 0, 0, "t6_r1");
    step(0, 1, 0, 2'b00, 0, 0, "t6_r2");
    step(0, 1, 0, 2'b10, 1, 0, "t6_r3");

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge clk_2);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
